// File: rtl/lcd_byte_writer.sv
// ---------------------------------------------------------------------------
// LcdByteWriter (module lcd_byte_writer)
//
// Purpose:
//   Sits after the stream timing adapter and turns each accepted byte of the
//   LCD master's 8-bit Avalon-ST stream into one HD44780-style 8-bit parallel
//   bus write. Each write has a setup phase, an enable pulse, a hold phase and
//   an execution wait. The escape byte ESC_BYTE marks the following byte as a
//   command (RS=0). Every other byte is display data (RS=1). Upstream is held
//   off with in_ready while power-up, a write or an execution wait is running.
//
// Ports:
//   clk       in   1  system clock
//   reset_n   in   1  asynchronous active-low reset
//   in_valid  in   1  Avalon-ST valid from the timing adapter
//   in_data   in   8  Avalon-ST byte
//   in_ready  out  1  Avalon-ST ready, high only while idle
//   lcd_rs    out  1  register select (1 = data, 0 = command)
//   lcd_rw    out  1  read/write, tied to write (0)
//   lcd_e     out  1  enable strobe
//   lcd_data  out  8  LCD data bus
//   busy      out  1  high whenever the writer is not idle
//
// All timing parameters count clock cycles and must be at least 1.
// ---------------------------------------------------------------------------
module lcd_byte_writer #(
    parameter int         T_POWERUP_CYC = 750000,
    parameter int         T_SETUP_CYC   = 3,
    parameter int         T_EN_CYC      = 12,
    parameter int         T_HOLD_CYC    = 2,
    parameter int         T_EXEC_CYC    = 1850,
    parameter int         T_LONG_CYC    = 76000,
    parameter logic [7:0] ESC_BYTE      = 8'hFE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       busy
);

    // Largest phase length. It sizes the single shared down-counter.
    function automatic int maxCycles();
        int m;
        m = T_POWERUP_CYC;
        if (T_SETUP_CYC > m) m = T_SETUP_CYC;
        if (T_EN_CYC    > m) m = T_EN_CYC;
        if (T_HOLD_CYC  > m) m = T_HOLD_CYC;
        if (T_EXEC_CYC  > m) m = T_EXEC_CYC;
        if (T_LONG_CYC  > m) m = T_LONG_CYC;
        return m;
    endfunction

    localparam int MAX_CYC = maxCycles();
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // The counter is loaded with length-1 on entry to a phase. The phase ends
    // on the edge where the counter reads zero, so a phase of length L
    // occupies exactly L cycles.
    localparam cnt_t POWERUP_LOAD = cnt_t'(T_POWERUP_CYC - 1);
    localparam cnt_t SETUP_LOAD   = cnt_t'(T_SETUP_CYC - 1);
    localparam cnt_t EN_LOAD      = cnt_t'(T_EN_CYC - 1);
    localparam cnt_t HOLD_LOAD    = cnt_t'(T_HOLD_CYC - 1);
    localparam cnt_t EXEC_LOAD    = cnt_t'(T_EXEC_CYC - 1);
    localparam cnt_t LONG_LOAD    = cnt_t'(T_LONG_CYC - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       cmdPending_q, cmdPending_d;
    logic       lcdRs_q, lcdRs_d;
    logic       lcdE_q, lcdE_d;
    logic [7:0] lcdData_q, lcdData_d;

    logic       transfer;
    logic       cntDone;
    logic       longWrite;

    // A byte moves only while idle. in_ready is decoded straight from the
    // state so that it can never be high outside IDLE.
    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign transfer = in_valid && in_ready;
    assign cntDone  = (cnt_q == '0);

    // Clear (0x01) and home (0x02/0x03) need the long execution time. Only
    // commands qualify, so the decision uses the latched RS and data. Both
    // stay stable from the latch until the next accepted byte.
    assign longWrite = !lcdRs_q &&
                       ((lcdData_q == 8'h01) || (lcdData_q[7:1] == 7'h01));

    // State, counter and bus registers. Reset drops the strobe at once,
    // forgets any pending escape and restarts the power-up wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            cnt_q        <= POWERUP_LOAD;
            cmdPending_q <= 1'b0;
            lcdRs_q      <= 1'b0;
            lcdE_q       <= 1'b0;
            lcdData_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmdPending_q <= cmdPending_d;
            lcdRs_q      <= lcdRs_d;
            lcdE_q       <= lcdE_d;
            lcdData_q    <= lcdData_d;
        end
    end

    // Next-state logic. The strobe's next value is decided together with the
    // phase change so that lcd_e is registered and lines up with the
    // ENABLE phase exactly.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmdPending_d = cmdPending_q;
        lcdRs_d      = lcdRs_q;
        lcdE_d       = lcdE_q;
        lcdData_d    = lcdData_q;

        case (state_q)
            ST_INIT: begin
                lcdE_d = 1'b0;
                if (cntDone) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_IDLE: begin
                lcdE_d = 1'b0;
                if (transfer) begin
                    if ((in_data == ESC_BYTE) && !cmdPending_q) begin
                        // A bare escape only arms command mode. The bus is
                        // untouched and the writer stays ready.
                        cmdPending_d = 1'b1;
                    end else begin
                        // An escaped escape byte lands here as command 0xFE.
                        lcdData_d    = in_data;
                        lcdRs_d      = !cmdPending_q;
                        cmdPending_d = 1'b0;
                        cnt_d        = SETUP_LOAD;
                        state_d      = ST_SETUP;
                    end
                end
            end

            ST_SETUP: begin
                if (cntDone) begin
                    lcdE_d  = 1'b1;
                    cnt_d   = EN_LOAD;
                    state_d = ST_ENABLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_ENABLE: begin
                if (cntDone) begin
                    lcdE_d  = 1'b0;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_HOLD: begin
                if (cntDone) begin
                    cnt_d   = longWrite ? LONG_LOAD : EXEC_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_WAIT: begin
                if (cntDone) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                lcdE_d       = 1'b0;
                cmdPending_d = 1'b0;
                cnt_d        = POWERUP_LOAD;
                state_d      = ST_INIT;
            end
        endcase
    end

    assign lcd_rs   = lcdRs_q;
    assign lcd_e    = lcdE_q;
    assign lcd_data = lcdData_q;
    assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_byte_writer
//
// Drives lcd_byte_writer with short timing parameters. It runs directed byte
// sequences first and then a randomized byte stream. Each bus write is
// compared with a reference model that works from bytes, not from states.
// The model tracks the pending escape and the expected RS/data. It also
// predicts the strobe window and the cycle on which in_ready returns.
// ---------------------------------------------------------------------------
module tb_lcd_byte_writer;

    localparam int         P_POWERUP = 10;
    localparam int         P_SETUP   = 2;
    localparam int         P_EN      = 3;
    localparam int         P_HOLD    = 1;
    localparam int         P_EXEC    = 5;
    localparam int         P_LONG    = 20;
    localparam logic [7:0] ESC       = 8'hFE;
    localparam int         BOUND     = 200;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending escape and the last value on the bus.
    bit         modelPending;
    logic       modelRs;
    logic [7:0] modelData;

    lcd_byte_writer #(
        .T_POWERUP_CYC(P_POWERUP),
        .T_SETUP_CYC  (P_SETUP),
        .T_EN_CYC     (P_EN),
        .T_HOLD_CYC   (P_HOLD),
        .T_EXEC_CYC   (P_EXEC),
        .T_LONG_CYC   (P_LONG),
        .ESC_BYTE     (ESC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_data(lcd_data),
        .busy    (busy)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    // Stops the run if a wait somehow escapes its cycle bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Makes one comparison: counts it, and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call this on the negedge where reset is released. It counts edges until
    // the writer first becomes ready, and no strobe may appear before then.
    task automatic waitInit();
        int n;
        bit sawE;
        n    = 0;
        sawE = 1'b0;
        while (n < BOUND) begin
            @(negedge clk);
            n++;
            if (lcd_e) sawE = 1'b1;
            if (in_ready) break;
        end
        checkOutput("initLength", n, P_POWERUP);
        checkOutput("initNoStrobe", sawE, 1'b0);
    endtask

    // Offers one byte (after an optional idle gap with junk data), waits for
    // it to be accepted and then checks the result against the model. in_valid
    // is left high, so that calls made back to back give a held-valid stream.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int   k;
        int   eFirst;
        int   eCnt;
        int   w;
        logic expRs;
        bit   done;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk);

        if ((b == ESC) && !modelPending) begin
            modelPending = 1'b1;
            @(negedge clk);
            checkOutput("escReady", in_ready, 1'b1);
            checkOutput("escNoStrobe", lcd_e, 1'b0);
            checkOutput("escBusHeld", {lcd_rs, lcd_data}, {modelRs, modelData});
            return;
        end

        expRs        = !modelPending;
        modelPending = 1'b0;
        modelRs      = expRs;
        modelData    = b;
        w = (!expRs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? P_LONG : P_EXEC;

        k      = 0;
        eFirst = 0;
        eCnt   = 0;
        done   = 1'b0;
        while (k < BOUND) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                checkOutput("rs", lcd_rs, expRs);
                checkOutput("data", lcd_data, b);
                checkOutput("readyDrops", in_ready, 1'b0);
            end
            checkOutput("busyVsReady", busy, !in_ready);
            if (lcd_e) begin
                eCnt++;
                if (eFirst == 0) eFirst = k;
            end
            if (in_ready) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("readyTimeout", done, 1'b1);
        checkOutput("strobeStart", eFirst, P_SETUP + 1);
        checkOutput("strobeWidth", eCnt, P_EN);
        checkOutput("readyReturn", k, P_SETUP + P_EN + P_HOLD + w + 1);
        checkOutput("busHeld", {lcd_rs, lcd_data}, {expRs, b});
        checkOutput("rwLow", lcd_rw, 1'b0);
    endtask

    // Starts the command write 0x01 and then pulls reset while the strobe is
    // high. The strobe has to fall at once and the power-up wait has to repeat.
    task automatic resetDuringStrobe();
        int k;
        applyStimulus(ESC, 1);
        in_valid = 1'b1;
        in_data  = 8'h01;
        k = 0;
        while (!in_ready && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        modelPending = 1'b0;
        k = 0;
        while (!lcd_e && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        checkOutput("strobeBeforeReset", lcd_e, 1'b1);
        checkOutput("cmdRsBeforeReset", lcd_rs, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("resetDropsStrobe", lcd_e, 1'b0);
        checkOutput("resetReady", in_ready, 1'b0);
        checkOutput("resetBusy", busy, 1'b1);
        modelRs   = 1'b0;
        modelData = 8'h00;
        in_valid  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        waitInit();
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        int         gap;

        reset_n      = 1'b0;
        in_valid     = 1'b1;
        in_data      = 8'h41;
        modelPending = 1'b0;
        modelRs      = 1'b0;
        modelData    = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("rstReady", in_ready, 1'b0);
        checkOutput("rstBusy", busy, 1'b1);
        checkOutput("rstE", lcd_e, 1'b0);
        checkOutput("rstRs", lcd_rs, 1'b0);
        checkOutput("rstData", lcd_data, 8'h00);
        checkOutput("rstRw", lcd_rw, 1'b0);

        $display("[TB] power-up with valid byte waiting");
        reset_n = 1'b1;
        waitInit();
        applyStimulus(8'h41, 0);

        $display("[TB] escape then command 0x38");
        applyStimulus(ESC, 1);
        applyStimulus(8'h38, 0);

        $display("[TB] long and short commands");
        applyStimulus(ESC, 2);
        applyStimulus(8'h01, 0);
        applyStimulus(ESC, 0);
        applyStimulus(8'h02, 1);
        applyStimulus(ESC, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(ESC, 0);
        applyStimulus(8'h04, 0);
        applyStimulus(8'h01, 1);

        $display("[TB] escaped escape and held-valid stream");
        applyStimulus(ESC, 0);
        applyStimulus(ESC, 0);
        applyStimulus(8'h41, 0);
        applyStimulus(8'h42, 0);

        $display("[TB] reset during command strobe");
        resetDuringStrobe();
        applyStimulus(8'h41, 0);

        $display("[TB] reset with escape pending");
        applyStimulus(ESC, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        modelPending = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        waitInit();
        applyStimulus(8'h41, 0);

        $display("[TB] randomized stream");
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      b = ESC;
            else if (r < 40) b = 8'($urandom_range(1, 3));
            else             b = 8'($urandom);
            gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            applyStimulus(b, gap);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
